// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory port between instruction fetch and the memory
//   stage (loads/stores). One transaction is in flight at a time, sequenced
//   by a four-state FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   Data requests win ties. With ARB_FAIRNESS_EN defined, a streak counter
//   forces a fetch grant after MAX_STREAK consecutive data grants taken while
//   fetch was waiting. Without the macro, priority is strict data-over-fetch.
//
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   if_req_i/if_addr_i     fetch read request (held until if_ack_o)
//   if_ack_o/if_rdata_o    one-cycle fetch completion + instruction word
//   d_req_i, d_we_i,
//   d_addr_i, d_wdata_i,
//   d_be_i                 data request (held until d_ack_o)
//   d_ack_o/d_rdata_o      one-cycle data completion + load data
//   mem_req_o, mem_we_o,
//   mem_addr_o,
//   mem_wdata_o, mem_be_o  registered request to memory
//   mem_gnt_i              memory accepts the request
//   mem_rvalid_i,
//   mem_rdata_i            memory response (reads and writes)
//   busy_o                 FSM not in IDLE
//   owner_o                current owner, 0 = fetch, 1 = data
//
// Every output comes straight from a flop; there is no input-to-output
// combinational path.

module mem_port_arbiter #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  if_req_i,
  input  logic [AWIDTH-1:0]     if_addr_i,
  output logic                  if_ack_o,
  output logic [DWIDTH-1:0]     if_rdata_o,

  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [AWIDTH-1:0]     d_addr_i,
  input  logic [DWIDTH-1:0]     d_wdata_i,
  input  logic [DWIDTH/8-1:0]   d_be_i,
  output logic                  d_ack_o,
  output logic [DWIDTH-1:0]     d_rdata_o,

  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AWIDTH-1:0]     mem_addr_o,
  output logic [DWIDTH-1:0]     mem_wdata_o,
  output logic [DWIDTH/8-1:0]   mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DWIDTH-1:0]     mem_rdata_i,

  output logic                  busy_o,
  output logic                  owner_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // FSM strobes
  logic arb_go;     // IDLE with a pending request: latch the winner
  logic gnt_take;   // ISSUE and memory accepted
  logic rsp_take;   // WAIT and memory responded

  logic grant_data; // arbitration result, only meaningful with arb_go
  logic fetch_forced;

`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_STREAK + 1);

  // Consecutive data grants taken while fetch was also requesting.
  logic [SW-1:0] streak_q;

  assign fetch_forced = if_req_i && (streak_q == SW'(MAX_STREAK));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      streak_q <= '0;
    end else if (arb_go) begin
      // Any fetch grant, or an arbitration fetch did not take part in,
      // ends the streak; a data grant over a waiting fetch extends it.
      if (!if_req_i || !grant_data)
        streak_q <= '0;
      else if (streak_q != SW'(MAX_STREAK))
        streak_q <= streak_q + 1'b1;
    end
  end
`else
  // Strict priority. MAX_STREAK only matters with fairness enabled; this
  // term folds to 0 for every legal value (>= 1).
  assign fetch_forced = (MAX_STREAK < 1) && if_req_i;
`endif

  assign grant_data = d_req_i && !fetch_forced;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    arb_go   = 1'b0;
    gnt_take = 1'b0;
    rsp_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i || d_req_i) begin
          arb_go  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt_i) begin
          gnt_take = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          rsp_take = 1'b1;
          state_d  = RESP;
        end
      end
      // RESP is a dead cycle for arbitration: the requester sees its ack
      // and gets one edge to drop or change its request.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Request / response datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      owner_o     <= 1'b0;
      busy_o      <= 1'b0;
      if_ack_o    <= 1'b0;
      d_ack_o     <= 1'b0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
    end else begin
      busy_o   <= (state_d != IDLE);
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;

      if (arb_go) begin
        owner_o   <= grant_data;
        mem_req_o <= 1'b1;
        if (grant_data) begin
          mem_we_o    <= d_we_i;
          mem_addr_o  <= d_addr_i;
          mem_wdata_o <= d_wdata_i;
          mem_be_o    <= d_be_i;
        end else begin
          mem_we_o    <= 1'b0;
          mem_addr_o  <= if_addr_i;
          mem_wdata_o <= '0;
          mem_be_o    <= '0;
        end
      end

      // Fields stay put after the grant; only the request strobe drops.
      if (gnt_take) mem_req_o <= 1'b0;

      // rdata registers are written only here, so they hold between acks.
      if (rsp_take) begin
        if (owner_o) begin
          d_rdata_o <= mem_rdata_i;
          d_ack_o   <= 1'b1;
        end else begin
          if_rdata_o <= mem_rdata_i;
          if_ack_o   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single shared memory port between the fetch stage (instruction reads) and the memory stage (loads and stores driven by the decoded `memren`/`memwren` controls). It runs a four-state transaction FSM and allows one outstanding memory transaction at a time. Data requests win ties, subject to an optional starvation guard for fetch. It sits between the pipeline stages and the unified memory model, and its acks are the stall-release points for both stages.

## Interface
Parameters:
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, data width; byte-enable width is `DWIDTH/8`
- `MAX_STREAK`, 4, consecutive data grants allowed while fetch waits (fairness build only); legal range ≥1

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_ni`  in  1  asynchronous, active-low reset
- `if_req_i`  in  1  fetch read request; held until `if_ack_o`
- `if_addr_i`  in  AWIDTH  fetch address
- `if_ack_o`  out  1  one-cycle completion pulse to fetch
- `if_rdata_o`  out  DWIDTH  instruction word, valid with `if_ack_o`
- `d_req_i`  in  1  data request (`memren` | `memwren`); held until `d_ack_o`
- `d_we_i`  in  1  1 = store, 0 = load
- `d_addr_i`  in  AWIDTH  data address
- `d_wdata_i`  in  DWIDTH  store data
- `d_be_i`  in  DWIDTH/8  store byte enables
- `d_ack_o`  out  1  one-cycle completion pulse to the memory stage
- `d_rdata_o`  out  DWIDTH  load data, valid with `d_ack_o`
- `mem_req_o`  out  1  request to memory
- `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o`  out  1/AWIDTH/DWIDTH/DWIDTH/8  request fields
- `mem_gnt_i`  in  1  memory accepts the request this cycle
- `mem_rvalid_i`  in  1  response valid, for both reads and writes
- `mem_rdata_i`  in  DWIDTH  read data
- `busy_o`  out  1  FSM not in IDLE
- `owner_o`  out  1  current owner: 0 = fetch, 1 = data

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - If no request is pending, remain in IDLE.
  - Otherwise pick an owner, register its request fields into the `mem_*` outputs, and go to ISSUE.
- Arbitration priority: data over fetch. Exception: fetch wins when `if_req_i` is high and the streak counter equals `MAX_STREAK`.
- ISSUE:
  - `mem_req_o` is high and the request fields are stable.
  - Go to WAIT on the edge where `mem_gnt_i` is high; also drop `mem_req_o` on that edge.
- WAIT: on `mem_rvalid_i`, capture `mem_rdata_i` into the owner's rdata register and go to RESP.
- RESP:
  - The owner's ack is high for exactly one cycle.
  - No arbitration happens in this state, which gives the requester one edge to drop or change its request.
  - Next state is IDLE.
- `mem_rvalid_i` outside WAIT is ignored. `mem_gnt_i` outside ISSUE is ignored.
- Streak counter (`$clog2(MAX_STREAK+1)` bits):
  - Increments on a data grant while `if_req_i` is high.
  - Clears on a fetch grant.
  - Clears at any arbitration where `if_req_i` is low.
  - Saturates at `MAX_STREAK`.
- Request inputs are sampled only in IDLE. Changes during ISSUE, WAIT or RESP have no effect.
- Reset:
  - All outputs are 0, the FSM is in IDLE and the counter is 0.
  - Assertion mid-transaction abandons the transaction. Any later `mem_rvalid_i` is ignored, and no ack is produced.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- Minimum transaction, with request high at cycle 0:
  - `mem_req_o` high in cycle 1.
  - `mem_gnt_i` seen in cycle 1.
  - `mem_rvalid_i` seen in cycle 2.
  - Ack and rdata in cycle 3.
  - IDLE in cycle 4, where the next arbitration happens.
- Throughput: at most one transaction per 4 cycles.
- Ack latency from request: 3 + (grant wait cycles) + (response wait cycles).
- A stalled grant keeps ISSUE and all `mem_*` fields unchanged indefinitely.
- Both requests high in the same IDLE cycle: exactly one is granted. The loser stays pending and is arbitrated at the next IDLE.
- `if_rdata_o` and `d_rdata_o` hold their last captured value between acks.

## Configuration
- `ARB_FAIRNESS_EN` defined:
  - The streak counter is present.
  - Fetch is guaranteed a grant after at most `MAX_STREAK` consecutive data grants.
- `ARB_FAIRNESS_EN` undefined:
  - The counter is removed and `MAX_STREAK` is unused.
  - Priority is strict data-over-fetch; fetch can starve while `d_req_i` stays asserted.

## Test plan
- Reset: drive `rst_ni`=0. All outputs must be 0 and `busy_o`=0. Release reset; with no requests, `busy_o` stays 0.
- Single fetch: `if_req_i`=1, `if_addr_i`=0x1000, memory grants immediately and responds next cycle with 0x00500093.
  - `mem_req_o` must be high in cycle 1 with `mem_we_o`=0 and `mem_addr_o`=0x1000.
  - `if_ack_o` must pulse in cycle 3 with `if_rdata_o`=0x00500093.
  - `d_ack_o` must stay 0.
- Store with stalled grant: `d_req_i`=1, `d_we_i`=1, addr 0x2004, wdata 0xDEADBEEF, be 0xF, grant delayed 3 cycles.
  - All `mem_*` fields must stay unchanged for 4 ISSUE cycles.
  - `d_ack_o` must pulse exactly once.
- Simultaneous requests in IDLE: data must be granted first (`owner_o`=1). Fetch must be granted at the following IDLE once data drops its request.
- Fairness, `ARB_FAIRNESS_EN` defined, `MAX_STREAK`=4: hold both requests continuously.
  - Grant order must be D,D,D,D,F,D,D,D,D,F.
  - Without the macro, only data may be granted.
- Reset mid-transaction: pull `rst_ni` low in WAIT, then release, then drive `mem_rvalid_i`=1. No ack may be produced, and the FSM must return to IDLE.
